// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: per-register countdown counters gate ID issue; control outputs are combinational, state updates on the clock.
// Backpressure: stalls IF/ID on operand hazards, freezes everything on mem_busy, flushes IF/ID and ID/EX on redirect.
module scoreboard_hazard_unit #(
    parameter int NUM_REGS   = 32,
    parameter int ALU_LAT    = 0,
    parameter int LOAD_LAT   = 1,
    parameter int MULDIV_LAT = 4,
    parameter int WB_DIST    = 2,
    parameter int ECALL_REG  = 17,
    parameter int PERF_W     = 32,
    localparam int IDX_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [IDX_W-1:0]  id_rs1,
    input  logic [IDX_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [IDX_W-1:0]  id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mul_div,
    input  logic              id_is_ecall,
    input  logic              redirect,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              bubble,
    output logic              if_flush,
    output logic              id_flush,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    localparam int MAX_AL  = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
    localparam int MAX_MW  = (MULDIV_LAT > WB_DIST) ? MULDIV_LAT : WB_DIST;
    localparam int MAX_LAT = (MAX_AL > MAX_MW) ? MAX_AL : MAX_MW;
    localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0]  fwd_cnt_q [NUM_REGS];
    logic [CNT_W-1:0]  fwd_cnt_d [NUM_REGS];
    logic [CNT_W-1:0]  wb_cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]  wb_cnt_d  [NUM_REGS];
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_events_q, flush_events_d;
    logic              hazard;
    logic              issue;
    logic              stall_inc;
    logic              flush_inc;
    logic [CNT_W-1:0]  issue_lat;

    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            if (id_use_rs1 && (id_rs1 != '0) && (fwd_cnt_q[id_rs1] != '0)) hazard = 1'b1;
            if (id_use_rs2 && (id_rs2 != '0) && (fwd_cnt_q[id_rs2] != '0)) hazard = 1'b1;
            if (id_is_ecall && (wb_cnt_q[ECALL_REG] != '0))                 hazard = 1'b1;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        bubble      = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        issue       = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
        end else if (mem_busy) begin
            // EX keeps presenting any redirect, so it is picked up after the freeze.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (redirect) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            flush_inc = 1'b1;
        end else if (hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            bubble      = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            issue = id_valid && id_reg_write && (id_rd != '0);
        end
    end

    always_comb begin
        if (id_mul_div)       issue_lat = CNT_W'(MULDIV_LAT);
        else if (id_mem_read) issue_lat = CNT_W'(LOAD_LAT);
        else                  issue_lat = CNT_W'(ALU_LAT);
    end

    // x0 keeps zeroed counters; the issuing register reloads instead of decrementing.
    always_comb begin
        fwd_cnt_d[0] = '0;
        wb_cnt_d[0]  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            fwd_cnt_d[i] = fwd_cnt_q[i];
            wb_cnt_d[i]  = wb_cnt_q[i];
            if (!mem_busy) begin
                if (issue && (id_rd == IDX_W'(i))) begin
                    fwd_cnt_d[i] = issue_lat;
                    wb_cnt_d[i]  = CNT_W'(WB_DIST);
                end else begin
                    if (fwd_cnt_q[i] != '0) fwd_cnt_d[i] = fwd_cnt_q[i] - CNT_W'(1);
                    if (wb_cnt_q[i] != '0)  wb_cnt_d[i]  = wb_cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (stall_inc && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + PERF_W'(1);
        if (flush_inc && (flush_events_q != '1)) flush_events_d = flush_events_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                fwd_cnt_q[i] <= '0;
                wb_cnt_q[i]  <= '0;
            end
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                fwd_cnt_q[i] <= fwd_cnt_d[i];
                wb_cnt_q[i]  <= wb_cnt_d[i];
            end
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit; perf counters narrowed to 4 bits so saturation is reachable.
module tb_scoreboard_hazard_unit;

    localparam int PW = 4;
    localparam logic [4:0] ISSUE  = 5'b11000;
    localparam logic [4:0] STALL  = 5'b00100;
    localparam logic [4:0] FREEZE = 5'b00000;
    localparam logic [4:0] FLUSH  = 5'b11011;
    localparam logic [4:0] RST    = 5'b00100;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_mul_div, id_is_ecall;
    logic          redirect, mem_busy;
    logic          pc_write, if_id_write, bubble, if_flush, id_flush;
    logic [PW-1:0] stall_cycles, flush_events;

    int tests = 0;
    int fails = 0;

    scoreboard_hazard_unit #(.PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mul_div(id_mul_div),
        .id_is_ecall(id_is_ecall), .redirect(redirect), .mem_busy(mem_busy),
        .pc_write(pc_write), .if_id_write(if_id_write), .bubble(bubble),
        .if_flush(if_flush), .id_flush(id_flush),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks happen 4ns later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                         input int rd, input logic rw, input logic mr, input logic md, input logic ec);
        id_valid     = v;
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = 5'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mul_div   = md;
        id_is_ecall  = ec;
    endtask

    task automatic idle();
        instr(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_ctrl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        #3;
        obs = {pc_write, if_id_write, bubble, if_flush, id_flush};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag, input int exp_stall, input int exp_flush);
        tests++;
        assert (stall_cycles === PW'(exp_stall) && flush_events === PW'(exp_flush)) else begin
            fails++;
            $error("FAIL %s perf observed=%0d/%0d expected=%0d/%0d",
                   tag, stall_cycles, flush_events, exp_stall, exp_flush);
        end
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; mem_busy = 1'b0;
        idle();
        #1;
        chk_ctrl("reset_ctrl", RST);
        tick();
        chk_perf("reset_perf", 0, 0);
        reset = 1'b0;
        chk_ctrl("idle_after_reset", ISSUE);

        // lw x5 then add x6,x5,x1: one bubble
        instr(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); chk_ctrl("lw_issue", ISSUE); tick();
        instr(1, 5, 1, 1, 1, 6, 1, 0, 0, 0); chk_ctrl("load_use_stall", STALL); tick();
        chk_ctrl("load_use_release", ISSUE);
        chk_perf("load_use_perf", 1, 0);
        tick();

        // mul x7 then dependent sub: four bubbles
        instr(1, 2, 3, 1, 1, 7, 1, 0, 1, 0); chk_ctrl("mul_issue", ISSUE); tick();
        instr(1, 1, 7, 1, 1, 9, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk_ctrl($sformatf("mul_stall%0d", i), STALL); tick();
        end
        chk_ctrl("mul_release", ISSUE); tick();
        chk_perf("mul_perf", 5, 0);
        instr(1, 2, 3, 1, 1, 7, 1, 0, 1, 0); tick();
        instr(1, 8, 1, 1, 1, 10, 1, 0, 0, 0); chk_ctrl("mul_independent", ISSUE); tick();

        // addi x17 then ecall: two bubbles on the write-back distance
        instr(1, 1, 0, 1, 0, 17, 1, 0, 0, 0); tick();
        instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_ctrl("ecall_stall0", STALL); tick();
        chk_ctrl("ecall_stall1", STALL); tick();
        chk_ctrl("ecall_release", ISSUE); tick();
        instr(1, 1, 0, 1, 0, 17, 1, 0, 0, 0); tick();
        idle(); chk_ctrl("idle_no_stall", ISSUE); tick();
        tick();
        instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk_ctrl("ecall_late", ISSUE); tick();
        chk_perf("ecall_perf", 7, 0);

        // redirect beats a live load-use hazard; the flushed load x11 is not recorded
        instr(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); tick();
        instr(1, 5, 0, 1, 0, 11, 1, 1, 0, 0); redirect = 1'b1;
        chk_ctrl("redirect_flush", FLUSH); tick();
        redirect = 1'b0;
        chk_perf("redirect_perf", 7, 1);
        instr(1, 11, 5, 1, 1, 12, 1, 0, 0, 0); chk_ctrl("flushed_rd_free", ISSUE); tick();

        // freeze holds the load counter; redirect during freeze is ignored
        instr(1, 1, 0, 1, 0, 5, 1, 1, 0, 0); tick();
        instr(1, 5, 1, 1, 1, 6, 1, 0, 0, 0); mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            redirect = (i == 4);
            chk_ctrl($sformatf("freeze%0d", i), FREEZE); tick();
        end
        mem_busy = 1'b0; redirect = 1'b0;
        chk_perf("freeze_perf", 7, 1);
        chk_ctrl("post_freeze_stall", STALL); tick();
        chk_ctrl("post_freeze_release", ISSUE); tick();
        chk_perf("post_freeze_perf", 8, 1);

        // x0 is never tracked
        instr(1, 1, 0, 1, 0, 0, 1, 1, 0, 0); tick();
        instr(1, 0, 0, 1, 1, 13, 1, 0, 0, 0); chk_ctrl("x0_consumer", ISSUE); tick();

        // reset in the middle of a mul stall
        instr(1, 2, 3, 1, 1, 7, 1, 0, 1, 0); tick();
        instr(1, 7, 0, 1, 0, 14, 1, 0, 0, 0);
        chk_ctrl("pre_reset_stall", STALL); tick();
        reset = 1'b1;
        chk_ctrl("mid_reset_ctrl", RST); tick();
        reset = 1'b0;
        chk_ctrl("post_reset_issue", ISSUE);
        chk_perf("post_reset_perf", 0, 0);
        tick();

        // 20 stall cycles saturate a 4-bit counter at 15
        for (int k = 0; k < 5; k++) begin
            instr(1, 2, 3, 1, 1, 7, 1, 0, 1, 0); tick();
            instr(1, 7, 0, 1, 0, 14, 1, 0, 0, 0);
            repeat (4) tick();
            chk_ctrl($sformatf("sat_release%0d", k), ISSUE); tick();
        end
        chk_perf("stall_saturate", 15, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised next-generation hazard unit for the 5-stage RV32I pipeline.
- Replaces fixed rd==rs comparison against ID/EX with a per-register scoreboard of countdown counters.
- Supports configurable load, mul/div and ecall latencies, a global memory-busy freeze, control-redirect flush, and saturating stall/flush performance counters.

Parameters:
- NUM_REGS, 32, architectural registers tracked; index width = clog2(NUM_REGS).
- ALU_LAT, 0, bubbles required by an ALU-result consumer in ID.
- LOAD_LAT, 1, bubbles required by a load-result consumer in ID.
- MULDIV_LAT, 4, bubbles required by a mul/div-result consumer in ID.
- WB_DIST, 2, cycles after issue until the value is readable from the register file (ecall operand).
- ECALL_REG, 17, register implicitly read by ecall (a7).
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  clog2(NUM_REGS)  source 1 index
- id_rs2  in  clog2(NUM_REGS)  source 2 index
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  clog2(NUM_REGS)  destination index
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- id_mul_div  in  1  instruction is mul/div
- id_is_ecall  in  1  instruction is ecall
- redirect  in  1  EX resolved a taken branch, jal, jalr or mispredict
- mem_busy  in  1  data memory miss; whole pipeline frozen
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- bubble  out  1  zero control signals into ID/EX
- if_flush  out  1  squash IF/ID
- id_flush  out  1  squash ID/EX
- stall_cycles  out  PERF_W  count of hazard-stall cycles
- flush_events  out  PERF_W  count of redirect flushes

Behaviour:
- State:
  - fwd_cnt[NUM_REGS] and wb_cnt[NUM_REGS], each wide enough for max(ALU_LAT, LOAD_LAT, MULDIV_LAT, WB_DIST).
  - stall_cycles and flush_events.
  - All state is cleared to 0 on reset.
- Control outputs are combinational and evaluated in this priority order:
  1. reset: pc_write=0, if_id_write=0, bubble=1, if_flush=0, id_flush=0.
  2. mem_busy (freeze): pc_write=0, if_id_write=0, bubble=0, flushes=0. No counter changes; redirect is ignored, because EX holds it and re-presents it.
  3. redirect: pc_write=1, if_id_write=1, bubble=0, if_flush=1, id_flush=1. The ID instruction is not issued. flush_events increments.
  4. hazard: pc_write=0, if_id_write=0, bubble=1, flushes=0. stall_cycles increments. hazard is true when id_valid and any of:
     - id_use_rs1 && rs1!=0 && fwd_cnt[rs1]!=0
     - id_use_rs2 && rs2!=0 && fwd_cnt[rs2]!=0
     - id_is_ecall && wb_cnt[ECALL_REG]!=0
  5. otherwise: pc_write=1, if_id_write=1, bubble=0, flushes=0. The instruction issues if id_valid.
- Issue (clock edge, case 5 with id_valid && id_reg_write && id_rd!=0):
  - fwd_cnt[id_rd] is loaded with MULDIV_LAT if id_mul_div, else LOAD_LAT if id_mem_read, else ALU_LAT.
  - wb_cnt[id_rd] is loaded with WB_DIST.
  - A load overrides any in-flight older value for the same register; the issue load takes precedence over that register's decrement.
- Decrement (every clock edge where not reset and not mem_busy): every nonzero counter not being loaded decrements by 1, saturating at 0.
- Register x0 is never tracked; its counters stay 0.
- Perf counters saturate at all-ones; they do not wrap.
- Latency semantics: a producer issued at edge t with latency L makes a dependent instruction in ID stall exactly L cycles (no freeze).
- Reset mid-stall: the next cycle after reset deasserts, no hazard exists.

Test Plan:
- lw x5 issued, then add x6,x5,x1 in ID -> bubble=1, pc_write=0 for exactly 1 cycle, then issue; stall_cycles=1.
- mul x7 issued, then dependent sub on x7 -> 4 stall cycles; an independent instruction (rs1=x8) in the same position -> 0 stalls.
- addi x17 issued, then ecall -> 2 stall cycles (WB_DIST=2); ecall with an x17 writer issued 3 cycles earlier -> no stall.
- Load-use hazard active and redirect=1 in the same cycle -> if_flush=id_flush=1, bubble=0, pc_write=1; rd of the ID instruction not recorded; flush_events=1, stall_cycles unchanged.
- lw x5 issued, mem_busy held 5 cycles -> all enables 0, fwd_cnt[x5] stays 1; after release, consumer stalls exactly 1 cycle.
- Write to x0 via a load, then consumer of x0 -> no stall; reset asserted mid-stall -> counters 0, and the dependent instruction issues on the first post-reset cycle.
